// File: rtl/transi_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// transi_sequencer_pkg
//   Shared definitions for the transition-frame sequencer:
//   - FSM state encoding (kept as plain 2-bit constants so existing
//     decoders and debug probes that expect these codes keep working)
//   - channel-offset helper for slicing the packed multi-channel data bus
// -----------------------------------------------------------------------------
package transi_sequencer_pkg;

  localparam int TRANSISEQ_STATEWIDTH = 2;

  localparam logic [TRANSISEQ_STATEWIDTH-1:0] TRANSISEQ_IDLE = 2'b00;
  localparam logic [TRANSISEQ_STATEWIDTH-1:0] TRANSISEQ_PLAY = 2'b01;
  localparam logic [TRANSISEQ_STATEWIDTH-1:0] TRANSISEQ_DONE = 2'b10;

  // Bit offset of channel 'chan' in a packed bus of 'dataWidth'-bit channels.
  function automatic int chanOffset(input int chan, input int dataWidth);
    return chan * dataWidth;
  endfunction

endpackage

// File: rtl/transi_mux_reg.sv
// -----------------------------------------------------------------------------
// transi_mux_reg
//   Parametrised NCH:1 registered multiplexer.
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset (output clears to 0)
//     sel      in   SELWIDTH  channel index to register this cycle
//     dataIn   in   NCH*DATAWIDTH  packed channels, channel k at [k*DATAWIDTH +: DATAWIDTH]
//     dataOut  out  DATAWIDTH  registered selected channel
// -----------------------------------------------------------------------------
module transi_mux_reg
  import transi_sequencer_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NCH       = 4,
  parameter int SELWIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SELWIDTH-1:0]      sel,
  input  logic [NCH*DATAWIDTH-1:0] dataIn,
  output logic [DATAWIDTH-1:0]     dataOut
);

  logic [DATAWIDTH-1:0] picked;

  // Compare against every legal channel instead of indexing with sel directly,
  // so a non-power-of-two NCH never reads past the end of the bus.
  always_comb begin
    // NOTE: default assignment first so every path drives 'picked' -- no latch.
    picked = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELWIDTH'(k)) begin
        picked = dataIn[chanOffset(k, DATAWIDTH) +: DATAWIDTH];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut <= '0;
    end else begin
      dataOut <= picked;
    end
  end

endmodule

// File: rtl/transi_sequencer.sv
// -----------------------------------------------------------------------------
// transi_sequencer
//   N-channel transition-frame sequencer. Channel 0 is the idle pattern;
//   channels 1..NCH-1 are played in order on a start request, each held for a
//   programmable number of timebase ticks, then the block returns to idle
//   (one-cycle done pulse) or loops back to channel 1.
//   Ports:
//     CC_TRANSISEQ_CLOCK_50       in   system clock
//     CC_TRANSISEQ_RESET_InLow    in   asynchronous active-low reset
//     CC_TRANSISEQ_start_InLow    in   start request, active low, level-sampled
//     CC_TRANSISEQ_abort_InLow    in   abort request, active low, highest priority
//     CC_TRANSISEQ_loop_In        in   1 = restart at channel 1 after last frame
//     CC_TRANSISEQ_tick_In        in   single-cycle timebase enable
//     CC_TRANSISEQ_hold_InBUS     in   ticks per frame (0 treated as 1)
//     CC_TRANSISEQ_data_InBUS     in   packed channels
//     CC_TRANSISEQ_data_OutBUS    out  registered selected channel
//     CC_TRANSISEQ_select_OutBUS  out  currently selected channel index
//     CC_TRANSISEQ_busy_Out       out  high while playing
//     CC_TRANSISEQ_done_Out       out  one-cycle pulse at normal sequence end
// -----------------------------------------------------------------------------
module transi_sequencer
  import transi_sequencer_pkg::*;
#(
  parameter int TRANSISEQ_DATAWIDTH = 8,
  parameter int TRANSISEQ_NCH       = 4,
  parameter int TRANSISEQ_SELWIDTH  = 2,
  parameter int TRANSISEQ_HOLDWIDTH = 8
) (
  input  logic                                         CC_TRANSISEQ_CLOCK_50,
  input  logic                                         CC_TRANSISEQ_RESET_InLow,
  input  logic                                         CC_TRANSISEQ_start_InLow,
  input  logic                                         CC_TRANSISEQ_abort_InLow,
  input  logic                                         CC_TRANSISEQ_loop_In,
  input  logic                                         CC_TRANSISEQ_tick_In,
  input  logic [TRANSISEQ_HOLDWIDTH-1:0]               CC_TRANSISEQ_hold_InBUS,
  input  logic [TRANSISEQ_NCH*TRANSISEQ_DATAWIDTH-1:0] CC_TRANSISEQ_data_InBUS,
  output logic [TRANSISEQ_DATAWIDTH-1:0]               CC_TRANSISEQ_data_OutBUS,
  output logic [TRANSISEQ_SELWIDTH-1:0]                CC_TRANSISEQ_select_OutBUS,
  output logic                                         CC_TRANSISEQ_busy_Out,
  output logic                                         CC_TRANSISEQ_done_Out
);

  localparam logic [TRANSISEQ_SELWIDTH-1:0]  LAST_CH  = TRANSISEQ_SELWIDTH'(TRANSISEQ_NCH - 1);
  localparam logic [TRANSISEQ_SELWIDTH-1:0]  FIRST_CH = TRANSISEQ_SELWIDTH'(1);
  localparam logic [TRANSISEQ_HOLDWIDTH-1:0] ONE_HOLD = TRANSISEQ_HOLDWIDTH'(1);

  logic [TRANSISEQ_STATEWIDTH-1:0] state, stateNext;
  logic [TRANSISEQ_SELWIDTH-1:0]   selReg, selNext;
  logic [TRANSISEQ_HOLDWIDTH-1:0]  counter, counterNext;
  logic [TRANSISEQ_HOLDWIDTH-1:0]  latchedHold, latchedHoldNext;
  logic                            busyNext, doneNext;

  logic startReq, abortReq, frameEnd;

  assign startReq = !CC_TRANSISEQ_start_InLow;
  assign abortReq = !CC_TRANSISEQ_abort_InLow;
  // Last tick of the current frame. latchedHold is never 0 while playing,
  // so the subtraction cannot wrap.
  assign frameEnd = CC_TRANSISEQ_tick_In && (counter == latchedHold - ONE_HOLD);

  always_comb begin
    stateNext       = state;
    selNext         = selReg;
    counterNext     = counter;
    latchedHoldNext = latchedHold;
    busyNext        = 1'b0;
    doneNext        = 1'b0;

    if (abortReq) begin
      stateNext   = TRANSISEQ_IDLE;
      selNext     = '0;
      counterNext = '0;
    end else begin
      case (state)
        TRANSISEQ_IDLE: begin
          selNext = '0;
          if (startReq) begin
            stateNext       = TRANSISEQ_PLAY;
            selNext         = FIRST_CH;
            counterNext     = '0;
            busyNext        = 1'b1;
            latchedHoldNext = (CC_TRANSISEQ_hold_InBUS == '0) ? ONE_HOLD
                                                              : CC_TRANSISEQ_hold_InBUS;
          end
        end

        TRANSISEQ_PLAY: begin
          busyNext = 1'b1;
          if (frameEnd) begin
            counterNext = '0;
            if (selReg < LAST_CH) begin
              selNext = selReg + FIRST_CH;
            end else if (CC_TRANSISEQ_loop_In) begin
              selNext = FIRST_CH;
            end else begin
              stateNext = TRANSISEQ_DONE;
              selNext   = '0;
              busyNext  = 1'b0;
              doneNext  = 1'b1;
            end
          end else if (CC_TRANSISEQ_tick_In) begin
            counterNext = counter + ONE_HOLD;
          end
        end

        // DONE is a single-cycle marker; start is not looked at here, so a
        // held-low start relaunches only after passing through IDLE.
        TRANSISEQ_DONE: begin
          stateNext = TRANSISEQ_IDLE;
          selNext   = '0;
        end

        default: begin
          stateNext   = TRANSISEQ_IDLE;
          selNext     = '0;
          counterNext = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CC_TRANSISEQ_CLOCK_50 or negedge CC_TRANSISEQ_RESET_InLow) begin
    if (!CC_TRANSISEQ_RESET_InLow) begin
      state                 <= TRANSISEQ_IDLE;
      selReg                <= '0;
      counter               <= '0;
      latchedHold           <= '0;
      CC_TRANSISEQ_busy_Out <= 1'b0;
      CC_TRANSISEQ_done_Out <= 1'b0;
    end else begin
      state                 <= stateNext;
      selReg                <= selNext;
      counter               <= counterNext;
      latchedHold           <= latchedHoldNext;
      CC_TRANSISEQ_busy_Out <= busyNext;
      CC_TRANSISEQ_done_Out <= doneNext;
    end
  end

  assign CC_TRANSISEQ_select_OutBUS = selReg;

  // The mux registers the channel chosen by selNext, so data and select
  // update on the same edge and always stay aligned.
  transi_mux_reg #(
    .DATAWIDTH (TRANSISEQ_DATAWIDTH),
    .NCH       (TRANSISEQ_NCH),
    .SELWIDTH  (TRANSISEQ_SELWIDTH)
  ) u_dataMux (
    .clk     (CC_TRANSISEQ_CLOCK_50),
    .rst_n   (CC_TRANSISEQ_RESET_InLow),
    .sel     (selNext),
    .dataIn  (CC_TRANSISEQ_data_InBUS),
    .dataOut (CC_TRANSISEQ_data_OutBUS)
  );

endmodule

// File: tb/tb_transi_sequencer.sv
// -----------------------------------------------------------------------------
// tb_transi_sequencer
//   Directed self-checking bench for transi_sequencer (NCH = 4, 8-bit data).
//   Channels: ch0 = 0x00, ch1 = 0x81, ch2 = 0x42, ch3 = 0x24.
//   Each check compares the packed tuple {data, select, busy, done}.
// -----------------------------------------------------------------------------
module tb_transi_sequencer;

  logic        clk;
  logic        rst_n;
  logic        startInLow;
  logic        abortInLow;
  logic        loopIn;
  logic        tickIn;
  logic [7:0]  holdIn;
  logic [31:0] dataIn;
  logic [7:0]  dataOut;
  logic [1:0]  selectOut;
  logic        busyOut;
  logic        doneOut;

  int checks   = 0;
  int failures = 0;

  transi_sequencer #(
    .TRANSISEQ_DATAWIDTH (8),
    .TRANSISEQ_NCH       (4),
    .TRANSISEQ_SELWIDTH  (2),
    .TRANSISEQ_HOLDWIDTH (8)
  ) dut (
    .CC_TRANSISEQ_CLOCK_50      (clk),
    .CC_TRANSISEQ_RESET_InLow   (rst_n),
    .CC_TRANSISEQ_start_InLow   (startInLow),
    .CC_TRANSISEQ_abort_InLow   (abortInLow),
    .CC_TRANSISEQ_loop_In       (loopIn),
    .CC_TRANSISEQ_tick_In       (tickIn),
    .CC_TRANSISEQ_hold_InBUS    (holdIn),
    .CC_TRANSISEQ_data_InBUS    (dataIn),
    .CC_TRANSISEQ_data_OutBUS   (dataOut),
    .CC_TRANSISEQ_select_OutBUS (selectOut),
    .CC_TRANSISEQ_busy_Out      (busyOut),
    .CC_TRANSISEQ_done_Out      (doneOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] pk(input logic [7:0] d, input logic [1:0] s,
                                     input logic b, input logic dn);
    return {d, s, b, dn};
  endfunction

  function automatic logic [7:0] chData(input logic [1:0] s);
    case (s)
      2'd1:    return 8'h81;
      2'd2:    return 8'h42;
      2'd3:    return 8'h24;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] expected);
    logic [11:0] observed;
    observed = {dataOut, selectOut, busyOut, doneOut};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed{data,sel,busy,done}=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and check the tuple 1 time unit after the edge.
  task automatic cyc(input string tag, input logic [1:0] s, input logic b, input logic dn);
    @(posedge clk);
    #1;
    check(tag, pk(chData(s), s, b, dn));
  endtask

  initial begin
    rst_n      = 1'b0;
    startInLow = 1'b1;
    abortInLow = 1'b1;
    loopIn     = 1'b0;
    tickIn     = 1'b1;
    holdIn     = 8'd2;
    dataIn     = {8'h24, 8'h42, 8'h81, 8'h00};

    #12;
    check("reset_state", pk(8'h00, 2'd0, 1'b0, 1'b0));
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle for five cycles.
    for (int i = 0; i < 5; i++) cyc("idle", 2'd0, 1'b0, 1'b0);

    // Input change on ch0 appears one clock later while idle.
    dataIn[7:0] = 8'h5A;
    @(posedge clk);
    #1;
    check("data_follow", pk(8'h5A, 2'd0, 1'b0, 1'b0));
    dataIn[7:0] = 8'h00;
    cyc("data_restore", 2'd0, 1'b0, 1'b0);

    // Simultaneous start and abort in IDLE stays idle.
    startInLow = 1'b0;
    abortInLow = 1'b0;
    cyc("start_abort_idle", 2'd0, 1'b0, 1'b0);
    startInLow = 1'b1;
    abortInLow = 1'b1;

    // Single run, hold = 2, no loop.
    startInLow = 1'b0;
    cyc("run_ch1a", 2'd1, 1'b1, 1'b0);
    startInLow = 1'b1;
    cyc("run_ch1b", 2'd1, 1'b1, 1'b0);
    cyc("run_ch2a", 2'd2, 1'b1, 1'b0);
    cyc("run_ch2b", 2'd2, 1'b1, 1'b0);
    cyc("run_ch3a", 2'd3, 1'b1, 1'b0);
    cyc("run_ch3b", 2'd3, 1'b1, 1'b0);
    cyc("run_done", 2'd0, 1'b0, 1'b1);
    cyc("run_done_clear", 2'd0, 1'b0, 1'b0);
    cyc("run_idle", 2'd0, 1'b0, 1'b0);

    // Looping run: wraps back to ch1 with no done pulse.
    loopIn     = 1'b1;
    startInLow = 1'b0;
    cyc("loop_ch1a", 2'd1, 1'b1, 1'b0);
    startInLow = 1'b1;
    cyc("loop_ch1b", 2'd1, 1'b1, 1'b0);
    cyc("loop_ch2a", 2'd2, 1'b1, 1'b0);
    cyc("loop_ch2b", 2'd2, 1'b1, 1'b0);
    cyc("loop_ch3a", 2'd3, 1'b1, 1'b0);
    cyc("loop_ch3b", 2'd3, 1'b1, 1'b0);
    cyc("loop_wrap_ch1a", 2'd1, 1'b1, 1'b0);
    cyc("loop_wrap_ch1b", 2'd1, 1'b1, 1'b0);
    cyc("loop_wrap_ch2", 2'd2, 1'b1, 1'b0);
    abortInLow = 1'b0;
    cyc("loop_abort", 2'd0, 1'b0, 1'b0);
    abortInLow = 1'b1;
    loopIn     = 1'b0;
    cyc("loop_abort_idle", 2'd0, 1'b0, 1'b0);

    // Abort on the third PLAY cycle.
    startInLow = 1'b0;
    cyc("abort_play1", 2'd1, 1'b1, 1'b0);
    startInLow = 1'b1;
    cyc("abort_play2", 2'd1, 1'b1, 1'b0);
    cyc("abort_play3", 2'd2, 1'b1, 1'b0);
    abortInLow = 1'b0;
    cyc("abort_taken", 2'd0, 1'b0, 1'b0);
    abortInLow = 1'b1;
    cyc("abort_no_done", 2'd0, 1'b0, 1'b0);
    cyc("abort_idle", 2'd0, 1'b0, 1'b0);

    // hold = 0 treated as 1, tick every 3rd cycle; hold change mid-run ignored.
    holdIn     = 8'd0;
    tickIn     = 1'b0;
    startInLow = 1'b0;
    cyc("h0_start", 2'd1, 1'b1, 1'b0);
    startInLow = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      logic [1:0] s;
      tickIn = (c % 3 == 0);
      if (c == 4) holdIn = 8'd5;
      s = (c < 3) ? 2'd1 : (c < 6) ? 2'd2 : (c < 9) ? 2'd3 : 2'd0;
      cyc($sformatf("h0_c%0d", c), s, (c < 9), (c == 9));
    end
    tickIn = 1'b1;

    // Start held low relaunches after DONE -> IDLE; hold = 1.
    holdIn     = 8'd1;
    startInLow = 1'b0;
    cyc("relaunch_ch1", 2'd1, 1'b1, 1'b0);
    cyc("relaunch_ch2", 2'd2, 1'b1, 1'b0);
    cyc("relaunch_ch3", 2'd3, 1'b1, 1'b0);
    cyc("relaunch_done", 2'd0, 1'b0, 1'b1);
    cyc("relaunch_idle", 2'd0, 1'b0, 1'b0);
    cyc("relaunch_again", 2'd1, 1'b1, 1'b0);
    startInLow = 1'b1;
    abortInLow = 1'b0;
    cyc("relaunch_abort", 2'd0, 1'b0, 1'b0);
    abortInLow = 1'b1;

    // Asynchronous reset during ch2 frame, then a fresh start.
    holdIn     = 8'd2;
    startInLow = 1'b0;
    cyc("rst_ch1a", 2'd1, 1'b1, 1'b0);
    startInLow = 1'b1;
    cyc("rst_ch1b", 2'd1, 1'b1, 1'b0);
    cyc("rst_ch2a", 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_zero", pk(8'h00, 2'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("rst_held", pk(8'h00, 2'd0, 1'b0, 1'b0));
    #2;
    rst_n = 1'b1;
    cyc("rst_post_idle", 2'd0, 1'b0, 1'b0);
    startInLow = 1'b0;
    cyc("rst_restart_ch1a", 2'd1, 1'b1, 1'b0);
    startInLow = 1'b1;
    cyc("rst_restart_ch1b", 2'd1, 1'b1, 1'b0);
    cyc("rst_restart_ch2", 2'd2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transi_sequencer.md
Name: transi_sequencer

Overview:
- N-channel, parametrised successor to the 4-way transition-output selector.
- Channel 0 is the idle ("NADA") pattern; channels 1..NCH-1 are transition frames.
- On a start pulse the block plays the frames in order, holding each for a programmable number of tick pulses, then returns to idle or loops.
- Sits between the per-frame pattern generators and the row/matrix driver; output is registered.

Parameters:
- TRANSISEQ_DATAWIDTH, 8, width of each channel and of the output.
- TRANSISEQ_NCH, 4, channel count including idle channel 0; legal range 2..16.
- TRANSISEQ_SELWIDTH, 2, select width; must equal clog2(NCH).
- TRANSISEQ_HOLDWIDTH, 8, width of the hold-count input and the internal tick counter.

Ports:
- CC_TRANSISEQ_CLOCK_50  in  1  system clock; all state changes on the rising edge.
- CC_TRANSISEQ_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_TRANSISEQ_start_InLow  in  1  start request; active-low level, sampled each clock.
- CC_TRANSISEQ_abort_InLow  in  1  abort request; active-low level, sampled each clock.
- CC_TRANSISEQ_loop_In  in  1  1 = restart at channel 1 after the last frame.
- CC_TRANSISEQ_tick_In  in  1  single-cycle timebase enable from an external prescaler.
- CC_TRANSISEQ_hold_InBUS  in  HOLDWIDTH  ticks per frame.
- CC_TRANSISEQ_data_InBUS  in  NCH*DATAWIDTH  packed channels; channel k occupies bits [k*DATAWIDTH +: DATAWIDTH].
- CC_TRANSISEQ_data_OutBUS  out  DATAWIDTH  registered selected channel.
- CC_TRANSISEQ_select_OutBUS  out  SELWIDTH  currently selected channel index.
- CC_TRANSISEQ_busy_Out  out  1  high while in PLAY.
- CC_TRANSISEQ_done_Out  out  1  one-cycle pulse at normal sequence end.

Behaviour:
- Reset (asynchronous, active low):
  - data_Out = 0, select = 0, busy = 0, done = 0.
  - State = IDLE; tick counter = 0; latched hold = 0.
- Output path:
  - Each clock, data_Out <= data_In[channel of the next-state select].
  - data_Out and select_Out are therefore always aligned.
  - An input data change appears on data_Out one clock later.
- States: IDLE, PLAY, DONE.
- IDLE:
  - select = 0, busy = 0.
  - start = 0 and abort = 1 -> PLAY next cycle: select = 1, busy = 1, counter = 0.
  - hold_InBUS is latched at this edge; a latched value of 0 is treated as 1.
- PLAY, on each cycle with tick = 1:
  - If counter == latched_hold - 1: counter = 0 and the frame advances; otherwise counter increments.
  - Cycles with tick = 0 leave the counter unchanged.
- Frame advance:
  - select < NCH-1 -> select + 1.
  - select == NCH-1 and loop = 1 -> select = 1; loop is sampled at this edge.
  - select == NCH-1 and loop = 0 -> DONE.
- DONE: lasts exactly one cycle.
  - select = 0, busy = 0, done = 1.
  - Next state is always IDLE, regardless of start.
- Abort has highest priority in every state.
  - abort = 0 -> IDLE next cycle: select = 0, counter = 0, done stays 0.
  - In IDLE, simultaneous start and abort -> stay in IDLE.
- start is ignored while in PLAY or DONE; changes to hold are ignored until the next start.
- Start is level-sampled: start held low continuously immediately relaunches after each DONE→IDLE.
- Reset asserted mid-PLAY -> all outputs return to reset values immediately (asynchronous); no done pulse.
- Counter arithmetic is unsigned HOLDWIDTH-bit and never wraps, because the latched hold is at most 2^HOLDWIDTH - 1.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'b00, PLAY = 2'b01, DONE = 2'b10;
  - the packed-bus slice helper constant for channel offsets.
- One natural sub-module: transi_mux_reg.
  - A parametrised NCH:1 registered mux with async active-low reset.
  - Instantiated for the data path; the FSM and counter stay in transi_sequencer.

Test Plan:
- Common setup: NCH = 4; ch0 = 0x00, ch1 = 0x81, ch2 = 0x42, ch3 = 0x24; tick = 1 every cycle; hold = 2; loop = 0.
- Reset then idle 5 cycles -> data_Out = 0x00, select = 0, busy = 0, done = 0 throughout.
- One-cycle start pulse -> data_Out sequence 0x81, 0x81, 0x42, 0x42, 0x24, 0x24, then 0x00 with done = 1 for exactly 1 cycle; busy high for 6 cycles.
- Same stimulus with loop = 1 -> after 0x24, 0x24 the output returns to 0x81; no done pulse; busy stays 1.
- Start, then abort on the 3rd PLAY cycle -> next cycle select = 0, data_Out = 0x00, busy = 0, done never asserted.
- hold = 0, tick every 3rd cycle -> each frame lasts exactly 1 tick (3 clocks); changing hold to 5 mid-sequence has no effect.
- Reset low during ch2 frame -> outputs zero immediately without waiting for a clock edge; after release, state is IDLE and a new start begins again at ch1.
